// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and helpers for the memory-access stage
package core_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [5:0] REG_ZERO = 6'd0;

  // Halves must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (size == MEM_H && off[0] != 1'b0)
      bad = 1'b1;
    if (size == MEM_W && off != 2'b00)
      bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      MEM_B:   strb = 4'b0001 << off;
      MEM_H:   strb = off[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      MEM_B:   d = {4{wdata[7:0]}};
      MEM_H:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - lane select and sign/zero extension of a loaded word
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {byte_off, 3'b000};

  always_comb begin
    data = shifted;
    case (size)
      MEM_B:   data = is_unsigned ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   data = is_unsigned ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: loads/stores over a request bus and write-back pulse
module mem_access
  import core_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_result,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_wdata,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic              in_reg_write_enabled,
  input  logic [5:0]        in_reg_write_dest,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write_enabled,
  output logic [5:0]        wb_reg_write_dest,
  output logic [31:0]       wb_data,
  output logic              fault,
  output logic              busy
);

  state_e state, state_nxt;

  logic              accept;
  logic              mem_op;
  logic              bad_op;
  logic [ADDR_W-1:0] addr_lo;

  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [3:0]        lat_wstrb;
  logic [31:0]       lat_wdata;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic              lat_reg_we;
  logic [5:0]        lat_dest;
  logic [31:0]       load_data;

  assign addr_lo = in_addr[ADDR_W-1:0];
  assign accept  = in_valid && in_ready;
  assign mem_op  = in_mem_read || in_mem_write;
  assign bad_op  = mem_op && ((in_size == 2'd3) || (in_mem_read && in_mem_write) ||
                              is_misaligned(in_size, addr_lo[1:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Responses only count in WAIT, so a response coincident with the handshake is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && mem_op && !bad_op) state_nxt = ST_REQ;
      ST_REQ:  if (mem_req_ready)               state_nxt = ST_WAIT;
      ST_WAIT: if (mem_resp_valid)              state_nxt = ST_IDLE;
      default:                                  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state == ST_IDLE);
    busy          = (state != ST_IDLE);
    mem_req_valid = (state == ST_REQ);
    mem_req_we    = lat_we;
    mem_req_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
    mem_req_wdata = lat_wdata;
    mem_req_wstrb = lat_wstrb;
  end

  load_align u_load_align (
    .rdata       (mem_resp_rdata),
    .byte_off    (lat_addr[1:0]),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .data        (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr             <= '0;
      lat_we               <= 1'b0;
      lat_wstrb            <= 4'b0;
      lat_wdata            <= 32'b0;
      lat_size             <= 2'b0;
      lat_unsigned         <= 1'b0;
      lat_reg_we           <= 1'b0;
      lat_dest             <= REG_ZERO;
      wb_valid             <= 1'b0;
      wb_reg_write_enabled <= 1'b0;
      wb_reg_write_dest    <= REG_ZERO;
      wb_data              <= 32'b0;
      fault                <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      if (state == ST_IDLE && accept) begin
        if (!mem_op) begin
          wb_valid             <= 1'b1;
          wb_data              <= in_result;
          wb_reg_write_enabled <= in_reg_write_enabled && (in_reg_write_dest != REG_ZERO);
          wb_reg_write_dest    <= in_reg_write_dest;
        end else if (bad_op) begin
          fault <= 1'b1;
        end else begin
          lat_addr     <= addr_lo;
          lat_we       <= in_mem_write;
          lat_wstrb    <= in_mem_write ? store_strb(in_size, addr_lo[1:0]) : 4'b0;
          lat_wdata    <= in_mem_write ? store_data(in_size, in_wdata) : 32'b0;
          lat_size     <= in_size;
          lat_unsigned <= in_unsigned;
          lat_reg_we   <= in_reg_write_enabled;
          lat_dest     <= in_reg_write_dest;
        end
      end else if (state == ST_WAIT && mem_resp_valid) begin
        wb_valid             <= 1'b1;
        wb_data              <= lat_we ? 32'b0 : load_data;
        wb_reg_write_enabled <= !lat_we && lat_reg_we && (lat_dest != REG_ZERO);
        wb_reg_write_dest    <= lat_dest;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_result, in_addr, in_wdata;
  logic        in_mem_read, in_mem_write, in_unsigned, in_reg_write_enabled;
  logic [1:0]  in_size;
  logic [5:0]  in_reg_write_dest;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        wb_valid, wb_reg_write_enabled, fault, busy;
  logic [5:0]  wb_reg_write_dest;
  logic [31:0] wb_data;

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .in_reg_write_enabled(in_reg_write_enabled), .in_reg_write_dest(in_reg_write_dest),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .wb_valid(wb_valid), .wb_reg_write_enabled(wb_reg_write_enabled),
    .wb_reg_write_dest(wb_reg_write_dest), .wb_data(wb_data),
    .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [5:0]  dest;
    logic        chk_data;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  wb_t  exp_wb[$];
  req_t exp_req[$];
  int   exp_fault = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input int size, input bit uns);
    logic [31:0] v;
    v = rdata >> (8 * (addr % 4));
    if (size == 0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (size == 1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] addr, input int size);
    int off;
    off = addr % 4;
    if (size == 0) return 4'(1 << off);
    if (size == 1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int size);
    if (size == 0) return (wd & 32'hFF) * 32'h01010101;
    if (size == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_valid) begin
        check("wb_expected", 32'(exp_wb.size() != 0), 32'd1);
        if (exp_wb.size() != 0) begin
          wb_t e;
          e = exp_wb.pop_front();
          check("wb_reg_we", 32'(wb_reg_write_enabled), 32'(e.we));
          if (e.we) check("wb_dest", 32'(wb_reg_write_dest), 32'(e.dest));
          if (e.chk_data) check("wb_data", wb_data, e.data);
        end
      end
      if (fault) begin
        check("fault_expected", 32'(exp_fault != 0), 32'd1);
        check("fault_no_wb", 32'(wb_valid), 32'd0);
        if (exp_fault != 0) exp_fault--;
      end
      if (mem_req_valid) begin
        check("req_expected", 32'(exp_req.size() != 0), 32'd1);
        if (exp_req.size() != 0) begin
          check("req_addr", mem_req_addr, exp_req[0].addr);
          check("req_we", 32'(mem_req_we), 32'(exp_req[0].we));
          check("req_wstrb", 32'(mem_req_wstrb), 32'(exp_req[0].wstrb));
          check("req_wdata", mem_req_wdata, exp_req[0].wdata);
          if (mem_req_ready) void'(exp_req.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] result, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit rd, input bit wr, input int size, input bit uns,
                       input bit we, input logic [5:0] dest);
    in_valid             = 1'b1;
    in_result            = result;
    in_addr              = addr;
    in_wdata             = wdata;
    in_mem_read          = rd;
    in_mem_write         = wr;
    in_size              = 2'(size);
    in_unsigned          = uns;
    in_reg_write_enabled = we;
    in_reg_write_dest    = dest;
  endtask

  task automatic mem_op(input logic [31:0] addr, input logic [31:0] wdata, input bit wr,
                        input int size, input bit uns, input bit we, input logic [5:0] dest,
                        input int stall, input logic [31:0] rdata, input bit early_resp);
    req_t r;
    wb_t  w;
    r.addr  = addr & 32'hFFFF_FFFC;
    r.we    = wr;
    r.wstrb = wr ? model_strb(addr, size) : 4'h0;
    r.wdata = wr ? model_wdata(wdata, size) : 32'h0;
    exp_req.push_back(r);
    w.data     = model_load(rdata, addr, size, uns);
    w.we       = !wr && we && (dest != 6'd0);
    w.dest     = dest;
    w.chk_data = !wr;
    exp_wb.push_back(w);
    drive(32'h0, addr, wdata, !wr, wr, size, uns, we, dest);
    tick();
    in_valid = 1'b0;
    check("req_valid_after_accept", 32'(mem_req_valid), 32'd1);
    check("ready_low_in_req", 32'(in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      mem_resp_valid = early_resp;
      mem_resp_rdata = 32'h5A5A_5A5A;
      tick();
      check("stall_ready_low", 32'(in_ready), 32'd0);
      check("stall_req_held", 32'(mem_req_valid), 32'd1);
    end
    mem_req_ready  = 1'b1;
    mem_resp_valid = early_resp;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    check("req_dropped", 32'(mem_req_valid), 32'd0);
    check("ready_low_in_wait", 32'(in_ready), 32'd0);
    check("no_wb_on_early_resp", 32'(wb_valid), 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0;
    check("wb_pulse", 32'(wb_valid), 32'd1);
    check("ready_back", 32'(in_ready), 32'd1);
    tick();
    check("wb_single", 32'(wb_valid), 32'd0);
  endtask

  task automatic fault_op(input logic [31:0] addr, input bit rd, input bit wr, input int size);
    exp_fault++;
    drive(32'h0, addr, 32'h0, rd, wr, size, 1'b0, 1'b1, 6'd3);
    tick();
    in_valid = 1'b0;
    check("fault_pulse", 32'(fault), 32'd1);
    check("fault_ready", 32'(in_ready), 32'd1);
    check("fault_no_req", 32'(mem_req_valid), 32'd0);
    tick();
    check("fault_single", 32'(fault), 32'd0);
    check("fault_still_no_req", 32'(mem_req_valid), 32'd0);
  endtask

  initial begin
    wb_t  w;
    req_t r;
    rst            = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 6'd0);
    in_valid = 1'b0;

    check("model_half_signed", model_load(32'h8001_7FFF, 32'h202, 1, 1'b0), 32'hFFFF_8001);
    check("model_byte_wdata", model_wdata(32'hAB, 0), 32'hABAB_ABAB);
    check("model_byte_strb", 32'(model_strb(32'h103, 0)), 32'h8);
    check("model_byte_unsigned", model_load(32'h1234_80FF, 32'h301, 0, 1'b1), 32'h80);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    tick();

    w.data = 32'h1234; w.we = 1'b1; w.dest = 6'd5; w.chk_data = 1'b1;
    exp_wb.push_back(w);
    exp_wb.push_back(w);
    drive(32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 2, 1'b0, 1'b1, 6'd5);
    tick();
    check("alu_lat1_valid", 32'(wb_valid), 32'd1);
    check("alu_lat1_data", wb_data, 32'h1234);
    check("alu_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("alu_b2b_valid", 32'(wb_valid), 32'd1);
    check("alu_ready2", 32'(in_ready), 32'd1);
    tick();

    mem_op(32'h103, 32'hAB, 1'b1, 0, 1'b0, 1'b1, 6'd7, 0, 32'h0, 1'b1);
    mem_op(32'h202, 32'h0, 1'b0, 1, 1'b0, 1'b1, 6'd9, 3, 32'h8001_7FFF, 1'b1);

    fault_op(32'h6, 1'b1, 1'b0, 2);
    fault_op(32'h0, 1'b1, 1'b0, 3);
    fault_op(32'h8, 1'b1, 1'b1, 2);
    fault_op(32'h201, 1'b0, 1'b1, 1);

    mem_op(32'h10, 32'h0, 1'b0, 2, 1'b0, 1'b1, 6'd0, 0, 32'hDEAD_BEEF, 1'b0);
    mem_op(32'h301, 32'h0, 1'b0, 0, 1'b1, 1'b1, 6'd33, 1, 32'h1234_80FF, 1'b0);
    mem_op(32'h301, 32'h0, 1'b0, 0, 1'b0, 1'b1, 6'd4, 0, 32'h1234_80FF, 1'b0);
    mem_op(32'h12, 32'h1234_BEEF, 1'b1, 1, 1'b0, 1'b1, 6'd2, 0, 32'h0, 1'b0);
    mem_op(32'h20, 32'hCAFE_F00D, 1'b1, 2, 1'b0, 1'b0, 6'd2, 1, 32'h0, 1'b0);
    mem_op(32'h44, 32'h0, 1'b0, 2, 1'b0, 1'b0, 6'd8, 2, 32'h0BAD_F00D, 1'b0);

    r.addr = 32'h40; r.we = 1'b0; r.wstrb = 4'h0; r.wdata = 32'h0;
    exp_req.push_back(r);
    drive(32'h0, 32'h40, 32'h0, 1'b1, 1'b0, 2, 1'b0, 1'b1, 6'd6);
    tick();
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_req_valid", 32'(mem_req_valid), 32'd0);
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    check("late_resp_no_wb", 32'(wb_valid), 32'd0);
    check("late_resp_idle", 32'(busy), 32'd0);
    tick();

    w.data = 32'h55AA; w.we = 1'b0; w.dest = 6'd0; w.chk_data = 1'b1;
    exp_wb.push_back(w);
    drive(32'h55AA, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 6'd0);
    tick();
    in_valid = 1'b0;
    check("alu_x0_valid", 32'(wb_valid), 32'd1);
    check("alu_x0_we", 32'(wb_reg_write_enabled), 32'd0);
    tick();
    tick();

    check("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
    check("req_queue_drained", 32'(exp_req.size()), 32'd0);
    check("faults_drained", 32'(exp_fault), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Consumer of the execute stage's output bundle: `result`, memory enable/address, register write enable/destination.
- Performs loads and stores against data memory over a valid/ready request bus with a separate response channel.
- Produces a single-cycle write-back pulse toward the register file.
- Stalls upstream via `in_ready` while a memory transaction is outstanding.

Parameters:
ADDR_W, 32, data-memory byte-address width (low ADDR_W bits of `in_addr` are used)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  execute bundle valid
in_ready  out  1  stage can accept bundle
in_result  in  32  ALU result / non-memory write-back value
in_addr  in  32  memory byte address (mem_write_dest equivalent)
in_wdata  in  32  store data
in_mem_read  in  1  load op
in_mem_write  in  1  store op
in_size  in  2  0=byte 1=half 2=word (3 illegal)
in_unsigned  in  1  zero-extend load
in_reg_write_enabled  in  1  op writes a register
in_reg_write_dest  in  6  destination register (int+fp space)
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=store
mem_req_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
mem_req_wdata  out  32  lane-replicated store data
mem_req_wstrb  out  4  byte enables
mem_resp_valid  in  1  response valid (loads and store acks)
mem_resp_rdata  in  32  full word read
wb_valid  out  1  one-cycle retire pulse
wb_reg_write_enabled  out  1  write register file
wb_reg_write_dest  out  6  destination
wb_data  out  32  write-back value
fault  out  1  one-cycle misaligned/illegal pulse
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0 except `in_ready`=1; state IDLE. Asynchronous; takes effect mid-transaction. Afterwards any late `mem_resp_valid` is ignored.
- States: IDLE, REQ, WAIT. `in_ready` = (state==IDLE). Accept = `in_valid` && `in_ready`.
- IDLE, accept, no memory op:
  - Next cycle `wb_valid`=1 with `wb_data`=`in_result`.
  - `wb_reg_write_enabled` = `in_reg_write_enabled` && dest!=0.
  - Latency 1; back-to-back accepts allowed.
- IDLE, accept, memory op; latch bundle. Fault conditions:
  - size==3;
  - read && write both set;
  - half with addr[0]!=0;
  - word with addr[1:0]!=0.
- On fault: next cycle `fault`=1, `wb_valid`=0, remain IDLE.
- Otherwise go to REQ; `mem_req_valid`=1 from the next cycle.
- REQ:
  - Hold `mem_req_*` stable until `mem_req_ready`. On handshake, `mem_req_valid`<=0 and go to WAIT.
  - `mem_resp_valid` in REQ is ignored.
- Store encoding:
  - byte: wstrb = 1<<addr[1:0], wdata = {4{wdata[7:0]}}
  - half: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}
  - word: wstrb = 4'hF
- Loads: `mem_req_wstrb`=0 and `mem_req_wdata`=0.
- WAIT, on `mem_resp_valid`, next cycle `wb_valid`=1 and state returns to IDLE:
  - Load: select lane by latched addr[1:0], then sign- or zero-extend per `in_unsigned`. `wb_reg_write_enabled` = latched enable && dest!=0.
  - Store: `wb_reg_write_enabled`=0; the pulse still retires the instruction.
- Response timing: a response in the same cycle as the request handshake is not permitted by the bus; it is ignored.
- Minimum memory-op latency: accept→req 1 cycle, then req→resp ≥1 cycle, then resp→wb 1 cycle.
- `wb_valid` and `fault` are single-cycle pulses. No write-back backpressure.

Decomposition:
- Shared package (`core_pkg`):
  - mem_size enum (MEM_B, MEM_H, MEM_W);
  - state enum;
  - constant REG_ZERO=6'd0.
- One natural sub-module: `load_align` (combinational lane select + extend), reused later by the fp load path.

Test Plan:
- ALU passthrough:
  - Stimulus: result=0x1234, dest=5, we=1, two consecutive cycles.
  - Response: wb_valid on each following cycle, data 0x1234, `in_ready` stays 1.
- Byte store:
  - Stimulus: addr=0x103, wdata=0xAB, size=0.
  - Response: req addr=0x100, wstrb=4'b1000, wdata=0xABABABAB, we=1. Resp ack → wb_valid with reg_we=0.
- Signed half load with stalled memory:
  - Stimulus: addr=0x202, size=1, signed; `mem_req_ready` low 3 cycles; rdata=0x8001_7FFF.
  - Response: req held stable 4 cycles; wb_data=0xFFFF8001; `in_ready`=0 throughout.
- Misaligned word:
  - Stimulus: addr=0x6, size=2.
  - Response: fault pulse, no mem_req_valid, no wb_valid, `in_ready` stays 1.
- x0 destination:
  - Stimulus: load to dest=0 with rdata=0xDEADBEEF.
  - Response: wb_valid=1, wb_reg_write_enabled=0.
- Reset mid-WAIT:
  - Stimulus: assert rst during WAIT; resp arrives after release.
  - Response: outputs clear immediately, response ignored, no wb_valid.
